// File: rtl/omsp_atom_irq_gate_if.sv
// Bundle between the interrupt frontend/atomicity monitor side (master) and the IRQ gate (slave).
// Handshake: irq_detect acts as valid with irq_vec_id as payload; irq_ack is a one-cycle ready pulse
// that completes the transfer only in a cycle where irq_detect=1, and is ignored in any other cycle.
interface omsp_atom_irq_gate_if #(
   parameter int NIRQ   = 14,
   parameter int LAT_W  = 8,
   parameter int VCNT_W = 4
);
   logic [NIRQ-1:0]   irq_in;
   logic              gie;
   logic              atom_violation;
   logic              exec_boundary;
   logic              irq_ack;
   logic              stat_clr;
   logic              irq_detect;
   logic [3:0]        irq_vec_id;
   logic [NIRQ-1:0]   irq_acc;
   logic              viol_pending;
   logic [VCNT_W-1:0] viol_cnt;
   logic [LAT_W-1:0]  max_defer;
   logic [1:0]        dbg_state;

   modport master (
      output irq_in, gie, atom_violation, exec_boundary, irq_ack, stat_clr,
      input  irq_detect, irq_vec_id, irq_acc, viol_pending, viol_cnt, max_defer, dbg_state
   );

   modport slave (
      input  irq_in, gie, atom_violation, exec_boundary, irq_ack, stat_clr,
      output irq_detect, irq_vec_id, irq_acc, viol_pending, viol_cnt, max_defer, dbg_state
   );
endinterface

// File: rtl/omsp_atom_irq_gate.sv
// IRQ latch/arbiter that defers maskable requests while gie is low, turns atomicity
// violations into a non-maskable fault vector, and tracks deferral/violation statistics.
module omsp_atom_irq_gate #(
   parameter int NIRQ   = 14,
   parameter int LAT_W  = 8,
   parameter int VCNT_W = 4
) (
   input logic mclk,
   input logic puc_rst_n,
   omsp_atom_irq_gate_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, DEFER = 2'd1, REQ = 2'd2} state_t;

   localparam logic [3:0] VIOL_ID = 4'(NIRQ);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [3:0]        r_sel_id;
   logic [LAT_W-1:0]  r_defer_cnt;
   logic [LAT_W-1:0]  r_max_defer;
   logic              r_viol_pending;
   logic [VCNT_W-1:0] r_viol_cnt;
   logic [NIRQ-1:0]   r_acc;

   logic              w_any_irq;
   logic              w_pend;
   logic              w_elig;
   logic [3:0]        w_irq_hi;
   logic [3:0]        w_new_id;
   logic              w_sel_is_viol;
   logic              w_src_live;
   logic [NIRQ-1:0]   w_onehot;
   logic              w_detect;
   logic              w_ack_ok;
   logic [LAT_W-1:0]  w_cnt_inc;

   assign w_any_irq     = |bus.irq_in;
   assign w_pend        = w_any_irq | r_viol_pending;
   assign w_elig        = r_viol_pending | (w_any_irq & bus.gie);
   assign w_new_id      = r_viol_pending ? VIOL_ID : w_irq_hi;
   assign w_sel_is_viol = (r_sel_id == VIOL_ID);
   assign w_detect      = (r_state == REQ) & (bus.gie | w_sel_is_viol);
   assign w_ack_ok      = bus.irq_ack & w_detect;
   assign w_cnt_inc     = (r_defer_cnt == '1) ? r_defer_cnt : r_defer_cnt + LAT_W'(1);

   // Highest index wins; the loop also decodes the latched id for liveness and accept.
   always_comb begin
      w_irq_hi   = '0;
      w_onehot   = '0;
      w_src_live = w_sel_is_viol & r_viol_pending;
      for (int i = 0; i < NIRQ; i++) begin
         if (bus.irq_in[i]) w_irq_hi = 4'(i);
         if (r_sel_id == 4'(i)) begin
            w_onehot[i] = 1'b1;
            w_src_live  = bus.irq_in[i];
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_pend & w_elig & bus.exec_boundary) w_state_nxt = REQ;
            else if (w_pend)                         w_state_nxt = DEFER;
         end
         DEFER: begin
            if (w_elig & bus.exec_boundary) w_state_nxt = REQ;
            else if (!w_pend)               w_state_nxt = IDLE;
         end
         REQ: begin
            if (w_ack_ok)         w_state_nxt = IDLE;
            else if (!w_src_live) w_state_nxt = IDLE;
            else if (!w_detect)   w_state_nxt = DEFER;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge mclk or negedge puc_rst_n) begin
      if (!puc_rst_n) begin
         r_state        <= IDLE;
         r_sel_id       <= '0;
         r_defer_cnt    <= '0;
         r_max_defer    <= '0;
         r_viol_pending <= 1'b0;
         r_viol_cnt     <= '0;
         r_acc          <= '0;
      end else begin
         r_state <= w_state_nxt;
         if ((r_state != REQ) && (w_state_nxt == REQ)) r_sel_id <= w_new_id;

         // Counter reports the number of cycles spent in DEFER, including the exit cycle.
         if ((r_state != DEFER) && (w_state_nxt == DEFER)) r_defer_cnt <= '0;
         else if (r_state == DEFER)                        r_defer_cnt <= w_cnt_inc;

         if (bus.stat_clr) r_max_defer <= '0;
         else if ((r_state == DEFER) && (w_state_nxt == REQ) && (w_cnt_inc > r_max_defer))
            r_max_defer <= w_cnt_inc;

         if (bus.atom_violation)            r_viol_pending <= 1'b1;
         else if (w_ack_ok & w_sel_is_viol) r_viol_pending <= 1'b0;

         if (bus.stat_clr)                                   r_viol_cnt <= '0;
         else if (bus.atom_violation && (r_viol_cnt != '1)) r_viol_cnt <= r_viol_cnt + VCNT_W'(1);

         r_acc <= (w_ack_ok & ~w_sel_is_viol) ? w_onehot : '0;
      end
   end

   assign bus.irq_detect   = w_detect;
   assign bus.irq_vec_id   = r_sel_id;
   assign bus.irq_acc      = r_acc;
   assign bus.viol_pending = r_viol_pending;
   assign bus.viol_cnt     = r_viol_cnt;
   assign bus.max_defer    = r_max_defer;
   assign bus.dbg_state    = r_state;
endmodule

// File: tb/tb_omsp_atom_irq_gate.sv
// Directed bench for omsp_atom_irq_gate: reset, masking, priority, violation, gie drop, saturation.
module tb_omsp_atom_irq_gate;
   localparam int NIRQ = 14;
   localparam logic [1:0] S_IDLE = 2'd0, S_DEFER = 2'd1, S_REQ = 2'd2;

   logic mclk = 1'b0;
   logic puc_rst_n = 1'b0;
   int   n_total = 0;
   int   n_bad = 0;

   omsp_atom_irq_gate_if #(.NIRQ(NIRQ), .LAT_W(8), .VCNT_W(4)) bus ();

   omsp_atom_irq_gate #(.NIRQ(NIRQ), .LAT_W(8), .VCNT_W(4)) dut (
      .mclk      (mclk),
      .puc_rst_n (puc_rst_n),
      .bus       (bus)
   );

   always #5 mclk = ~mclk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge mclk);
      #1;
   endtask

   task automatic do_reset();
      bus.irq_in = '0; bus.gie = 1'b0; bus.atom_violation = 1'b0;
      bus.exec_boundary = 1'b1; bus.irq_ack = 1'b0; bus.stat_clr = 1'b0;
      #1 puc_rst_n = 1'b0;
      step(); step();
      puc_rst_n = 1'b1;
      step();
   endtask

   initial begin
      // Reset mid-request
      do_reset();
      chk("rst_detect", 32'(bus.irq_detect), 0);
      chk("rst_state", 32'(bus.dbg_state), 32'(S_IDLE));
      chk("rst_stats", {bus.max_defer, bus.viol_cnt, bus.viol_pending}, 0);
      bus.irq_in = 14'h0008; bus.gie = 1'b1;
      #1 chk("req_not_yet", 32'(bus.irq_detect), 0);
      step();
      chk("req3_detect", 32'(bus.irq_detect), 1);
      chk("req3_id", 32'(bus.irq_vec_id), 3);
      puc_rst_n = 1'b0;
      #1 chk("async_rst_detect", 32'(bus.irq_detect), 0);
      bus.irq_in = '0;
      step();
      puc_rst_n = 1'b1;
      step(); step();
      chk("rst_no_acc", 32'(bus.irq_acc), 0);

      // Masking: 20 deferred cycles before gie returns
      do_reset();
      bus.irq_in = 14'h0020; bus.gie = 1'b0;
      step();
      chk("mask_defer", 32'(bus.dbg_state), 32'(S_DEFER));
      repeat (19) step();
      chk("mask_no_detect", 32'(bus.irq_detect), 0);
      bus.gie = 1'b1;
      step();
      chk("mask_detect", 32'(bus.irq_detect), 1);
      chk("mask_id", 32'(bus.irq_vec_id), 5);
      chk("mask_max_defer", 32'(bus.max_defer), 20);
      bus.irq_ack = 1'b1;
      step();
      bus.irq_ack = 1'b0; bus.irq_in = '0;
      chk("mask_acc", 32'(bus.irq_acc), 32'h20);
      chk("mask_idle", 32'(bus.dbg_state), 32'(S_IDLE));
      step();
      chk("mask_acc_once", 32'(bus.irq_acc), 0);

      // Priority
      do_reset();
      bus.gie = 1'b1; bus.irq_in = 14'h0204;
      step();
      chk("prio_id9", 32'(bus.irq_vec_id), 9);
      bus.irq_ack = 1'b1;
      step();
      bus.irq_ack = 1'b0; bus.irq_in = 14'h0004;
      chk("prio_acc9", 32'(bus.irq_acc), 32'h200);
      step();
      chk("prio_detect2", 32'(bus.irq_detect), 1);
      chk("prio_id2", 32'(bus.irq_vec_id), 2);
      bus.irq_ack = 1'b1;
      step();
      bus.irq_ack = 1'b0; bus.irq_in = '0;
      chk("prio_acc2", 32'(bus.irq_acc), 32'h4);

      // Violation while gie=0
      do_reset();
      bus.gie = 1'b0; bus.irq_in = 14'h0010;
      step();
      chk("viol_defer", 32'(bus.dbg_state), 32'(S_DEFER));
      bus.atom_violation = 1'b1;
      step();
      bus.atom_violation = 1'b0;
      chk("viol_pending_set", 32'(bus.viol_pending), 1);
      chk("viol_cnt1", 32'(bus.viol_cnt), 1);
      step();
      chk("viol_detect", 32'(bus.irq_detect), 1);
      chk("viol_id", 32'(bus.irq_vec_id), 14);
      bus.irq_ack = 1'b1;
      step();
      bus.irq_ack = 1'b0; bus.irq_in = '0;
      chk("viol_pending_clr", 32'(bus.viol_pending), 0);
      chk("viol_no_acc", 32'(bus.irq_acc), 0);
      chk("viol_idle", 32'(bus.dbg_state), 32'(S_IDLE));

      // Same-cycle gie drop with ack
      do_reset();
      bus.gie = 1'b1; bus.irq_in = 14'h0040;
      step();
      chk("drop_detect", 32'(bus.irq_detect), 1);
      bus.gie = 1'b0; bus.irq_ack = 1'b1;
      #1 chk("drop_masked", 32'(bus.irq_detect), 0);
      step();
      bus.irq_ack = 1'b0;
      chk("drop_defer", 32'(bus.dbg_state), 32'(S_DEFER));
      chk("drop_no_acc", 32'(bus.irq_acc), 0);
      step();
      chk("drop_no_acc2", 32'(bus.irq_acc), 0);
      bus.gie = 1'b1;
      step();
      chk("drop_redetect", 32'(bus.irq_detect), 1);
      chk("drop_id", 32'(bus.irq_vec_id), 6);
      bus.irq_ack = 1'b1;
      step();
      bus.irq_ack = 1'b0; bus.irq_in = '0;
      chk("drop_acc6", 32'(bus.irq_acc), 32'h40);

      // Saturation and statistics clear
      do_reset();
      bus.gie = 1'b1;
      for (int i = 0; i < 20; i++) begin
         bus.atom_violation = 1'b1;
         step();
      end
      bus.atom_violation = 1'b0;
      chk("sat_viol_cnt", 32'(bus.viol_cnt), 15);
      step();
      chk("sat_viol_detect", 32'(bus.irq_detect), 1);
      bus.irq_ack = 1'b1;
      step();
      bus.irq_ack = 1'b0;
      chk("sat_viol_clr", 32'(bus.viol_pending), 0);
      bus.gie = 1'b0; bus.irq_in = 14'h0002;
      step();
      repeat (300) step();
      bus.gie = 1'b1;
      step();
      chk("sat_defer_detect", 32'(bus.irq_detect), 1);
      chk("sat_max_defer", 32'(bus.max_defer), 255);
      bus.irq_ack = 1'b1;
      step();
      bus.irq_ack = 1'b0; bus.irq_in = '0;
      bus.stat_clr = 1'b1; bus.atom_violation = 1'b1;
      step();
      bus.stat_clr = 1'b0; bus.atom_violation = 1'b0;
      chk("clr_viol_cnt", 32'(bus.viol_cnt), 0);
      chk("clr_max_defer", 32'(bus.max_defer), 0);
      chk("clr_pending_set", 32'(bus.viol_pending), 1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule
